// File: rtl/k10_uart_pkg.sv
// k10_uart_pkg: shared receiver FSM states, oversampling constants, vote helper.
// Used by k10_uart_rx and the sync FIFO side.
package k10_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;
    localparam int DATA_BITS  = 8;

    function automatic logic majority3(input logic a,
                                       input logic b,
                                       input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/k10_uart_rx_if.sv
// k10_uart_rx_if: valid/ready byte stream between the RX FIFO and its consumer.
// master drives valid/data, slave drives ready.
interface k10_uart_rx_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/k10_sync_fifo.sv
// k10_sync_fifo: generic first-word-fall-through FIFO with occupancy output.
// Read side is a valid/ready stream; empty head reads as zero.
module k10_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic [AW:0]      level_o,
    k10_uart_rx_if.master    rd
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             pop;
    logic             push_ok;

    assign pop      = rd.valid && rd.ready;
    assign full_o   = (level_q == FULL_LVL);
    // A pop in the same cycle frees the slot being written.
    assign push_ok  = push_i && (!full_o || pop);
    assign rd.valid = (level_q != '0);
    assign rd.data  = rd.valid ? mem_q[rptr_q] : '0;
    assign level_o  = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/k10_uart_rx.sv
// k10_uart_rx: 8N1 UART receiver, 16x oversampling, 3-sample majority vote.
// Define K10_UART_RX_PARITY_EN to add a parity bit, i_parity_odd and o_parity_err.
module k10_uart_rx
    import k10_uart_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    parameter int  DIV_W      = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_W-1:0]     i_baud_div,
    input  logic                 i_rx_en,
    input  logic                 i_rx,
`ifdef K10_UART_RX_PARITY_EN
    input  logic                 i_parity_odd,
    output logic                 o_parity_err,
`endif
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic [LW-1:0]        o_fifo_level,
    output logic                 o_busy
);
    localparam logic [3:0] SMP_A    = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] SMP_B    = 4'(SAMPLE_MID);
    localparam logic [3:0] SMP_EVAL = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
    localparam int         IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           smp_q, smp_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 line, tick, maj, at_eval, at_last;
    logic                 push, pop, fifo_full;
`ifdef K10_UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    k10_uart_rx_if #(.W(DATA_BITS)) rd_if ();

    assign line       = sync2_q;
    assign tick       = (state_q != IDLE) && (cnt_q == '0);
    assign maj        = majority3(sa_q, sb_q, line);
    assign at_eval    = tick && (smp_q == SMP_EVAL);
    assign at_last    = tick && (smp_q == SMP_LAST);
    assign pop        = rd_if.valid && rd_if.ready;
    assign rd_if.ready = i_rx_ready;
    assign o_rx_valid = rd_if.valid;
    assign o_rx_data  = rd_if.data;
    assign o_frame_err = ferr_q;
    assign o_overrun  = ovr_q;
    assign o_busy     = (state_q != IDLE);
`ifdef K10_UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        push    = 1'b0;
`ifdef K10_UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        // Tick phase is held at reload in IDLE so it aligns to the start edge.
        if (state_q == IDLE || tick) cnt_d = i_baud_div;
        else                         cnt_d = cnt_q - 1'b1;
        if (tick) begin
            smp_d = smp_q + 4'd1;
            if (smp_q == SMP_A) sa_d = line;
            if (smp_q == SMP_B) sb_d = line;
        end
        if (!i_rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (prev_q && !line) begin
                        state_d = START;
                        smp_d   = '0;
                    end
                end
                START: begin
                    if (at_eval && maj) begin
                        state_d = IDLE;
                    end else if (at_last) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (at_eval) shift_d[idx_q] = maj;
                    if (at_last) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
`ifdef K10_UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef K10_UART_RX_PARITY_EN
                PARITY: begin
                    if (at_eval) par_d = maj;
                    if (at_last) state_d = STOP;
                end
`endif
                STOP: begin
                    if (at_eval) begin
`ifdef K10_UART_RX_PARITY_EN
                        perr_d = par_q != ((^shift_q) ^ i_parity_odd);
`endif
                        if (maj) begin
                            if (fifo_full && !pop) ovr_d = 1'b1;
                            else                   push  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (line) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            smp_q   <= '0;
            sa_q    <= 1'b1;
            sb_q    <= 1'b1;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef K10_UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`endif

    k10_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (push),
        .data_i  (shift_q),
        .full_o  (fifo_full),
        .level_o (o_fifo_level),
        .rd      (rd_if)
    );

endmodule

// File: tb/tb_k10_uart_rx.sv
// tb_k10_uart_rx: directed vectors and corner sequences for k10_uart_rx.
// Honours K10_UART_RX_PARITY_EN when defined.
module tb_k10_uart_rx;
    localparam int DEPTH = 8;
    localparam int DIV   = 3;
    localparam int BIT   = 16 * (DIV + 1);
`ifdef K10_UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Cycles from line fall to the stop-bit evaluation edge (minus one).
    localparam int STOP_CYC = BIT * NB + 42;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_en;
    logic        rx;
    logic [15:0] baud_div;
    logic        ferr, ovr, busy;
    logic [3:0]  level;
`ifdef K10_UART_RX_PARITY_EN
    logic        parity_odd;
    logic        perr;
    logic        par_flip;
    int          perr_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int vhigh_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] popq[$];

    k10_uart_rx_if #(.W(8)) rx_if ();

    k10_uart_rx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_baud_div   (baud_div),
        .i_rx_en      (rx_en),
        .i_rx         (rx),
`ifdef K10_UART_RX_PARITY_EN
        .i_parity_odd (parity_odd),
        .o_parity_err (perr),
`endif
        .o_rx_valid   (rx_if.valid),
        .o_rx_data    (rx_if.data),
        .i_rx_ready   (rx_if.ready),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_fifo_level (level),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (ovr) ovr_cnt <= ovr_cnt + 1;
        if (rx_if.valid) vhigh_cnt <= vhigh_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rx_if.valid && rx_if.ready) popq.push_back(rx_if.data);
`ifdef K10_UART_RX_PARITY_EN
        if (perr) perr_cnt <= perr_cnt + 1;
`endif
    end

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         exp_level;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pq(input int i);
        return (i >= 0 && i < popq.size()) ? popq[i] : 8'hxx;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic tail, input int tail_bits);
        rx = 1'b0;
        tick_n(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick_n(BIT);
        end
`ifdef K10_UART_RX_PARITY_EN
        rx = (^b) ^ parity_odd ^ par_flip;
        tick_n(BIT);
`endif
        rx = stop;
        tick_n(BIT);
        rx = tail;
        tick_n(BIT * tail_bits);
    endtask

    task automatic drain(input int n);
        rx_if.ready = 1'b1;
        tick_n(n);
        rx_if.ready = 1'b0;
        tick_n(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, q0, v0, b0;
        rst_n       = 1'b0;
        rx          = 1'b1;
        rx_en       = 1'b1;
        baud_div    = 16'(DIV);
        rx_if.ready = 1'b0;
`ifdef K10_UART_RX_PARITY_EN
        parity_odd  = 1'b0;
        par_flip    = 1'b0;
`endif
        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b1, 1, 0};
        vecs[5] = '{8'h81, 1'b0, 0, 1};
        vecs[6] = '{8'h5A, 1'b1, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_if.valid), 32'd0);
        chk("rst_data", 32'(rx_if.data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick_n(5);

        // single byte with consumer always ready
        rx_if.ready = 1'b1;
        f0 = ferr_cnt; o0 = ovr_cnt; q0 = popq.size(); v0 = vhigh_cnt;
        send_frame(8'h55, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("b55_pops", 32'(popq.size() - q0), 32'd1);
        chk("b55_valid_cycles", 32'(vhigh_cnt - v0), 32'd1);
        chk("b55_data", 32'(pq(q0)), 32'h55);
        chk("b55_errs", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
        rx_if.ready = 1'b0;
        tick_n(1);

        // back-to-back frames, no idle bits
        send_frame(8'hA3, 1'b1, 1'b1, 0);
        send_frame(8'h00, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("b2b_level", 32'(level), 32'd3);
        chk("b2b_head", 32'(rx_if.data), 32'hA3);
        q0 = popq.size();
        drain(6);
        chk("b2b_pops", 32'(popq.size() - q0), 32'd3);
        chk("b2b_pop0", 32'(pq(q0)), 32'hA3);
        chk("b2b_pop1", 32'(pq(q0 + 1)), 32'h00);
        chk("b2b_pop2", 32'(pq(q0 + 2)), 32'hFF);

        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].din, vecs[i].stop, 1'b1, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_level", i), 32'(level),
                32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_valid", i), 32'(rx_if.valid),
                32'(vecs[i].exp_level != 0));
            if (vecs[i].exp_level != 0)
                chk($sformatf("vec%0d_data", i), 32'(rx_if.data),
                    32'(vecs[i].din));
            chk($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0),
                32'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'd0);
            drain(3);
        end

        // 20-clock glitch while idle
        f0 = ferr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        tick_n(20);
        rx = 1'b1;
        tick_n(100);
        @(negedge clk);
        chk("glitch_seen_busy", 32'(busy_cnt > b0), 32'd1);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_level", 32'(level), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // stop bit low, line stays low (break)
        f0 = ferr_cnt;
        send_frame(8'h12, 1'b0, 1'b0, 5);
        @(negedge clk);
        chk("brk_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("brk_busy", 32'(busy), 32'd1);
        chk("brk_level", 32'(level), 32'd0);
        rx = 1'b1;
        tick_n(10);
        @(negedge clk);
        chk("brk_release_busy", 32'(busy), 32'd0);
        chk("brk_ferr_once", 32'(ferr_cnt - f0), 32'd1);
        tick_n(BIT);

        // overrun: nine bytes into an eight-deep FIFO
        o0 = ovr_cnt;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("ovr_level", 32'(level), 32'd8);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_head", 32'(rx_if.data), 32'h01);

        // full FIFO, pop in the stop-evaluation cycle
        o0 = ovr_cnt; q0 = popq.size();
        tick_n(1);
        fork
            send_frame(8'h0A, 1'b1, 1'b1, 1);
            begin
                tick_n(STOP_CYC);
                rx_if.ready = 1'b1;
                tick_n(1);
                rx_if.ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("fullpop_level", 32'(level), 32'd8);
        chk("fullpop_ovr", 32'(ovr_cnt - o0), 32'd0);
        chk("fullpop_popped", 32'(pq(q0)), 32'h01);
        chk("fullpop_head", 32'(rx_if.data), 32'h02);
        q0 = popq.size();
        drain(12);
        chk("fullpop_drain_n", 32'(popq.size() - q0), 32'd8);
        chk("fullpop_last", 32'(pq(popq.size() - 1)), 32'h0A);

        // reset in the middle of data bit 4
        send_frame(8'h11, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("rst_pre_level", 32'(level), 32'd1);
        tick_n(1);
        fork
            send_frame(8'hF8, 1'b1, 1'b1, 1);
            begin
                tick_n(350);
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", 32'(rx_if.valid), 32'd0);
                chk("midrst_data", 32'(rx_if.data), 32'd0);
                chk("midrst_level", 32'(level), 32'd0);
                chk("midrst_busy", 32'(busy), 32'd0);
                tick_n(3);
                rst_n = 1'b1;
            end
        join
        @(negedge clk);
        chk("postrst_level", 32'(level), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        tick_n(1);
        send_frame(8'h3C, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("postrst_3c_level", 32'(level), 32'd1);
        chk("postrst_3c_data", 32'(rx_if.data), 32'h3C);
        drain(3);

        // receiver disabled mid-frame
        f0 = ferr_cnt;
        fork
            send_frame(8'hF8, 1'b1, 1'b1, 1);
            begin
                tick_n(300);
                rx_en = 1'b0;
                tick_n(1);
                @(negedge clk);
                chk("dis_busy", 32'(busy), 32'd0);
            end
        join
        rx_en = 1'b1;
        tick_n(5);
        @(negedge clk);
        chk("dis_level", 32'(level), 32'd0);
        chk("dis_ferr", 32'(ferr_cnt - f0), 32'd0);
        tick_n(1);

`ifdef K10_UART_RX_PARITY_EN
        // even parity: 0x07 needs parity bit 1
        f0 = perr_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("par_ok_level", 32'(level), 32'd1);
        chk("par_ok_data", 32'(rx_if.data), 32'h07);
        chk("par_ok_perr", 32'(perr_cnt - f0), 32'd0);
        drain(3);
        f0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("par_bad_level", 32'(level), 32'd1);
        chk("par_bad_data", 32'(rx_if.data), 32'h07);
        chk("par_bad_perr", 32'(perr_cnt - f0), 32'd1);
        par_flip = 1'b0;
        drain(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
